// File: rtl/sdr_app_arbiter.sv
// Two-port arbiter for the SDRAM application interface, with an owner-tag FIFO
// that steers read returns. Define SDR_ARB_ROUND_ROBIN_EN for round-robin, else port 1 has priority.
module sdr_app_arbiter #(
  parameter int ADDR_WIDTH = 21,
  parameter int DATA_WIDTH = 32,
  parameter int DM_WIDTH   = 4,
  parameter int BURST_MAX  = 256,
  parameter int TAG_DEPTH  = 16
) (
  input  logic                  mem_clk,
  input  logic                  rst,
  input  logic                  sdr_init_done,
  input  logic                  sdr_busy,
  input  logic                  p0_req,
  output logic                  p0_gnt,
  output logic                  p0_rdy,
  input  logic                  p0_wr_en,
  input  logic [ADDR_WIDTH-1:0] p0_wr_addr,
  input  logic [DM_WIDTH-1:0]   p0_wr_dm,
  input  logic [DATA_WIDTH-1:0] p0_wr_din,
  input  logic                  p0_rd_en,
  input  logic [ADDR_WIDTH-1:0] p0_rd_addr,
  output logic                  p0_rd_vld,
  output logic [DATA_WIDTH-1:0] p0_rd_dout,
  input  logic                  p1_req,
  output logic                  p1_gnt,
  output logic                  p1_rdy,
  input  logic                  p1_wr_en,
  input  logic [ADDR_WIDTH-1:0] p1_wr_addr,
  input  logic [DM_WIDTH-1:0]   p1_wr_dm,
  input  logic [DATA_WIDTH-1:0] p1_wr_din,
  input  logic                  p1_rd_en,
  input  logic [ADDR_WIDTH-1:0] p1_rd_addr,
  output logic                  p1_rd_vld,
  output logic [DATA_WIDTH-1:0] p1_rd_dout,
  output logic                  app_wr_en,
  output logic [ADDR_WIDTH-1:0] app_wr_addr,
  output logic [DM_WIDTH-1:0]   app_wr_dm,
  output logic [DATA_WIDTH-1:0] app_wr_din,
  output logic                  app_rd_en,
  output logic [ADDR_WIDTH-1:0] app_rd_addr,
  input  logic                  sdr_rd_en,
  input  logic [DATA_WIDTH-1:0] sdr_rd_dout,
  output logic                  owner,
  output logic                  rd_orphan
);
  localparam int PW = $clog2(TAG_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(BURST_MAX + 1);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_e;

  state_e                state_q;
  logic                  gnt0_q, gnt1_q, owner_q;
  logic [BW-1:0]         beat_cnt_q;
  logic                  app_wr_en_q, app_rd_en_q;
  logic [ADDR_WIDTH-1:0] app_wr_addr_q, app_rd_addr_q;
  logic [DM_WIDTH-1:0]   app_wr_dm_q;
  logic [DATA_WIDTH-1:0] app_wr_din_q;
  logic                  tag_mem [TAG_DEPTH];
  logic [PW-1:0]         wptr_q, rptr_q;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  vld0_q, vld1_q, orphan_q;
  logic [DATA_WIDTH-1:0] dout0_q, dout1_q;

  logic tag_afull, sel_wr, sel_rd, sel_req, acc, fwd_wr, fwd_rd, beat_last;
  logic push, pop, both_pick1;

  assign tag_afull = (cnt_q >= CW'(TAG_DEPTH - 1));
  assign p0_gnt    = gnt0_q;
  assign p1_gnt    = gnt1_q;
  assign p0_rdy    = gnt0_q & ~sdr_busy & ~tag_afull;
  assign p1_rdy    = gnt1_q & ~sdr_busy & ~tag_afull;

  assign sel_wr    = gnt1_q ? p1_wr_en : p0_wr_en;
  assign sel_rd    = gnt1_q ? p1_rd_en : p0_rd_en;
  assign sel_req   = gnt1_q ? p1_req   : p0_req;
  assign acc       = (p0_rdy | p1_rdy) & (sel_wr | sel_rd);
  assign fwd_wr    = acc & sel_wr;
  // A simultaneous read is dropped in favour of the write.
  assign fwd_rd    = acc & ~sel_wr & sel_rd;
  assign beat_last = acc & (beat_cnt_q == BW'(BURST_MAX - 1));

`ifdef SDR_ARB_ROUND_ROBIN_EN
  assign both_pick1 = ~owner_q;
`else
  assign both_pick1 = 1'b1;
`endif

  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      gnt0_q        <= 1'b0;
      gnt1_q        <= 1'b0;
      owner_q       <= 1'b0;
      beat_cnt_q    <= '0;
      app_wr_en_q   <= 1'b0;
      app_rd_en_q   <= 1'b0;
      app_wr_addr_q <= '0;
      app_wr_dm_q   <= '0;
      app_wr_din_q  <= '0;
      app_rd_addr_q <= '0;
    end else begin
      app_wr_en_q <= fwd_wr;
      app_rd_en_q <= fwd_rd;
      if (fwd_wr) begin
        app_wr_addr_q <= gnt1_q ? p1_wr_addr : p0_wr_addr;
        app_wr_dm_q   <= gnt1_q ? p1_wr_dm   : p0_wr_dm;
        app_wr_din_q  <= gnt1_q ? p1_wr_din  : p0_wr_din;
      end
      if (fwd_rd) app_rd_addr_q <= gnt1_q ? p1_rd_addr : p0_rd_addr;
      case (state_q)
        IDLE: begin
          beat_cnt_q <= '0;
          if (sdr_init_done && (p0_req || p1_req)) begin
            if (p1_req && (!p0_req || both_pick1)) begin
              state_q <= GNT1;
              gnt1_q  <= 1'b1;
              owner_q <= 1'b1;
            end else begin
              state_q <= GNT0;
              gnt0_q  <= 1'b1;
              owner_q <= 1'b0;
            end
          end
        end
        GNT0, GNT1: begin
          if (acc) beat_cnt_q <= beat_cnt_q + 1'b1;
          if (!sel_req || !sdr_init_done || beat_last) begin
            state_q <= IDLE;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          gnt0_q  <= 1'b0;
          gnt1_q  <= 1'b0;
        end
      endcase
    end
  end

  // Owner-tag FIFO: a pop on an empty FIFO is an orphan, even if a push lands the same edge.
  assign push = fwd_rd;
  assign pop  = sdr_rd_en & (cnt_q != '0);

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge mem_clk) begin
    if (push) tag_mem[wptr_q] <= gnt1_q;
  end

  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
      vld0_q   <= 1'b0;
      vld1_q   <= 1'b0;
      dout0_q  <= '0;
      dout1_q  <= '0;
      orphan_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      vld0_q <= pop & ~tag_mem[rptr_q];
      vld1_q <= pop &  tag_mem[rptr_q];
      if (pop && !tag_mem[rptr_q]) dout0_q <= sdr_rd_dout;
      if (pop &&  tag_mem[rptr_q]) dout1_q <= sdr_rd_dout;
      if (sdr_rd_en && cnt_q == '0) orphan_q <= 1'b1;
    end
  end

  assign app_wr_en   = app_wr_en_q;
  assign app_wr_addr = app_wr_addr_q;
  assign app_wr_dm   = app_wr_dm_q;
  assign app_wr_din  = app_wr_din_q;
  assign app_rd_en   = app_rd_en_q;
  assign app_rd_addr = app_rd_addr_q;
  assign p0_rd_vld   = vld0_q;
  assign p1_rd_vld   = vld1_q;
  assign p0_rd_dout  = dout0_q;
  assign p1_rd_dout  = dout1_q;
  assign owner       = owner_q;
  assign rd_orphan   = orphan_q;
endmodule
